mem_access: RTL and testbench

Memory-access (MEM) stage of the five-stage MIPS pipeline. Consumes the EX/MEM-latched results of the execute stage (destination, write enable, ALU result, aluop, store data, effective address). Performs loads and stores over a request/acknowledge data bus, with a stall request while a transfer is outstanding. Drives the registered write-back fields into WB.

---
 rtl/mem_access_pkg.sv | 23 ++
 rtl/mem_access_align.sv | 93 +++++++++
 rtl/mem_access.sv | 130 +++++++++++++
 tb/tb_mem_access.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared widths, memory aluop encodings and MEM-stage FSM states.
package mem_access_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALUOP_W    = 8;
    localparam int unsigned SEL_W      = 4;

    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_align.sv
// Big-endian lane steering: byte enables, store replication, load extraction.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [ALUOP_W-1:0] i_aluop,
    input  logic [1:0]         i_addr,
    input  logic [REG_W-1:0]   i_reg2,
    input  logic [REG_W-1:0]   i_rdata,
    output logic [SEL_W-1:0]   o_sel_c,
    output logic [REG_W-1:0]   o_wdata_c,
    output logic [REG_W-1:0]   o_load_data_c,
    output logic               o_misalign_c,
    output logic               o_is_load_c,
    output logic               o_is_store_c
);

    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [SEL_W-1:0] w_byte_sel;
    logic [SEL_W-1:0] w_half_sel;

    // Lane 0 (addr 00) is the most significant byte.
    always_comb begin
        w_byte     = i_rdata[31:24];
        w_byte_sel = 4'b1000;
        case (i_addr)
            2'b00: begin w_byte = i_rdata[31:24]; w_byte_sel = 4'b1000; end
            2'b01: begin w_byte = i_rdata[23:16]; w_byte_sel = 4'b0100; end
            2'b10: begin w_byte = i_rdata[15:8];  w_byte_sel = 4'b0010; end
            default: begin w_byte = i_rdata[7:0]; w_byte_sel = 4'b0001; end
        endcase
        w_half     = i_addr[1] ? i_rdata[15:0] : i_rdata[31:16];
        w_half_sel = i_addr[1] ? 4'b0011 : 4'b1100;
    end

    always_comb begin
        o_sel_c       = '0;
        o_wdata_c     = '0;
        o_load_data_c = '0;
        o_misalign_c  = 1'b0;
        o_is_load_c   = 1'b0;
        o_is_store_c  = 1'b0;
        case (i_aluop)
            EXE_LB_OP: begin
                o_is_load_c   = 1'b1;
                o_sel_c       = w_byte_sel;
                o_load_data_c = {{24{w_byte[7]}}, w_byte};
            end
            EXE_LBU_OP: begin
                o_is_load_c   = 1'b1;
                o_sel_c       = w_byte_sel;
                o_load_data_c = {24'h0, w_byte};
            end
            EXE_LH_OP: begin
                o_is_load_c   = 1'b1;
                o_sel_c       = w_half_sel;
                o_misalign_c  = i_addr[0];
                o_load_data_c = {{16{w_half[15]}}, w_half};
            end
            EXE_LHU_OP: begin
                o_is_load_c   = 1'b1;
                o_sel_c       = w_half_sel;
                o_misalign_c  = i_addr[0];
                o_load_data_c = {16'h0, w_half};
            end
            EXE_LW_OP: begin
                o_is_load_c   = 1'b1;
                o_sel_c       = 4'b1111;
                o_misalign_c  = |i_addr;
                o_load_data_c = i_rdata;
            end
            EXE_SB_OP: begin
                o_is_store_c = 1'b1;
                o_sel_c      = w_byte_sel;
                o_wdata_c    = {4{i_reg2[7:0]}};
            end
            EXE_SH_OP: begin
                o_is_store_c = 1'b1;
                o_sel_c      = w_half_sel;
                o_misalign_c = i_addr[0];
                o_wdata_c    = {2{i_reg2[15:0]}};
            end
            EXE_SW_OP: begin
                o_is_store_c = 1'b1;
                o_sel_c      = 4'b1111;
                o_misalign_c = |i_addr;
                o_wdata_c    = i_reg2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MIPS MEM stage: request/ack data-bus transfers with stall, MEM/WB output register.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      wdata_i,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [REG_W-1:0]      mem_addr_i,
    input  logic [REG_W-1:0]      reg2_i,
    input  logic                  dm_ack_i,
    input  logic [REG_W-1:0]      dm_rdata_i,
    output logic                  dm_req_o,
    output logic                  dm_we_o,
    output logic [REG_W-1:0]      dm_addr_o,
    output logic [SEL_W-1:0]      dm_sel_o,
    output logic [REG_W-1:0]      dm_wdata_o,
    output logic                  stallreq_o,
    output logic                  misalign_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o
);

    mem_state_e            r_state;
    logic                  r_dm_req;
    logic                  r_dm_we;
    logic [REG_W-1:0]      r_dm_addr;
    logic [SEL_W-1:0]      r_dm_sel;
    logic [REG_W-1:0]      r_dm_wdata;
    logic                  r_misalign;
    logic [REG_ADDR_W-1:0] r_wd;
    logic                  r_wreg;
    logic [REG_W-1:0]      r_wdata;

    logic [SEL_W-1:0] w_sel;
    logic [REG_W-1:0] w_wdata;
    logic [REG_W-1:0] w_load_data;
    logic             w_misalign;
    logic             w_is_load;
    logic             w_is_store;
    logic             w_mem_op;

    mem_align u_align (
        .i_aluop       (aluop_i),
        .i_addr        (mem_addr_i[1:0]),
        .i_reg2        (reg2_i),
        .i_rdata       (dm_rdata_i),
        .o_sel_c       (w_sel),
        .o_wdata_c     (w_wdata),
        .o_load_data_c (w_load_data),
        .o_misalign_c  (w_misalign),
        .o_is_load_c   (w_is_load),
        .o_is_store_c  (w_is_store)
    );

    assign w_mem_op = valid_i & (w_is_load | w_is_store);

    // Stall while a transfer is being launched or is still awaiting its ack.
    assign stallreq_o = (r_state == MEM_IDLE) ? (w_mem_op & ~w_misalign) : ~dm_ack_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= MEM_IDLE;
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_sel   <= '0;
            r_dm_wdata <= '0;
            r_misalign <= 1'b0;
            r_wd       <= '0;
            r_wreg     <= 1'b0;
            r_wdata    <= '0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                MEM_IDLE: begin
                    if (w_mem_op && w_misalign) begin
                        r_wd       <= wd_i;
                        r_wreg     <= 1'b0;
                        r_wdata    <= wdata_i;
                        r_misalign <= 1'b1;
                    end else if (w_mem_op) begin
                        r_dm_req   <= 1'b1;
                        r_dm_we    <= w_is_store;
                        r_dm_addr  <= {mem_addr_i[31:2], 2'b00};
                        r_dm_sel   <= w_sel;
                        r_dm_wdata <= w_wdata;
                        r_state    <= MEM_WAIT;
                        r_wd       <= '0;
                        r_wreg     <= 1'b0;
                        r_wdata    <= '0;
                    end else begin
                        r_wd    <= wd_i;
                        r_wreg  <= wreg_i & valid_i;
                        r_wdata <= wdata_i;
                    end
                end
                MEM_WAIT: begin
                    if (dm_ack_i) begin
                        r_dm_req <= 1'b0;
                        r_state  <= MEM_IDLE;
                        r_wd     <= wd_i;
                        r_wreg   <= w_is_load;
                        r_wdata  <= w_is_load ? w_load_data : wdata_i;
                    end else begin
                        r_wd    <= '0;
                        r_wreg  <= 1'b0;
                        r_wdata <= '0;
                    end
                end
                default: r_state <= MEM_IDLE;
            endcase
        end
    end

    assign dm_req_o   = r_dm_req;
    assign dm_we_o    = r_dm_we;
    assign dm_addr_o  = r_dm_addr;
    assign dm_sel_o   = r_dm_sel;
    assign dm_wdata_o = r_dm_wdata;
    assign misalign_o = r_misalign;
    assign wd_o       = r_wd;
    assign wreg_o     = r_wreg;
    assign wdata_o    = r_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: random ops against a byte-level memory model.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;
    logic        dm_req_o;
    logic        dm_we_o;
    logic [31:0] dm_addr_o;
    logic [3:0]  dm_sel_o;
    logic [31:0] dm_wdata_o;
    logic        stallreq_o;
    logic        misalign_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;

    mem_access dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o),
        .dm_addr_o(dm_addr_o), .dm_sel_o(dm_sel_o), .dm_wdata_o(dm_wdata_o),
        .stallreq_o(stallreq_o), .misalign_o(misalign_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
        int          delay;
    } bus_t;

    typedef struct {
        logic [4:0]  wd;
        logic [31:0] data;
    } wb_t;

    bus_t        bus_q[$];
    wb_t         wb_q[$];
    logic [31:0] mem [256];
    int          checks = 0;
    int          errors = 0;
    int          exp_mis = 0;
    int          seen_mis = 0;
    bit          abort_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [7:0] op);
        if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
        if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
        return 0;
    endfunction

    function automatic bit is_ld(input logic [7:0] op);
        return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
               op == EXE_LHU_OP || op == EXE_LW_OP;
    endfunction

    // Take n bytes starting at byte offset b of a big-endian word, then extend.
    function automatic logic [31:0] ld_model(input logic [7:0] op, input int b, input logic [31:0] rd);
        int n;
        logic [31:0] t, r;
        n = nbytes(op);
        t = rd << (8 * b);
        r = t >> (32 - 8 * n);
        if ((op == EXE_LB_OP || op == EXE_LH_OP) && t[31])
            r = r | ~(32'hFFFF_FFFF >> (32 - 8 * n));
        return r;
    endfunction

    task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                         input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                         input int delay, input logic vld);
        int n, b, exp_stall, stalls, idx;
        bit mis;
        bus_t e;
        wb_t w;
        logic [31:0] bw;
        n = nbytes(op);
        b = int'(addr[1:0]);
        idx = int'(addr[9:2]);
        mis = 1'b0;
        exp_stall = 0;
        if (vld && n != 0) begin
            mis = (b % n) != 0;
            if (mis) begin
                exp_mis++;
            end else begin
                bw = (n == 1) ? {4{r2[7:0]}} : (n == 2) ? {2{r2[15:0]}} : r2;
                e.addr  = {addr[31:2], 2'b00};
                e.sel   = 4'((32'(1) << n) - 1) << (4 - b - n);
                e.we    = !is_ld(op);
                e.wdata = bw;
                e.delay = delay;
                bus_q.push_back(e);
                exp_stall = 1 + delay;
                if (is_ld(op)) begin
                    w.wd = wd;
                    w.data = ld_model(op, b, mem[idx]);
                    wb_q.push_back(w);
                end else begin
                    for (int i = 0; i < 4; i++)
                        if (e.sel[i]) mem[idx][8*i +: 8] = bw[8*i +: 8];
                end
            end
        end else if (vld && wr) begin
            w.wd = wd;
            w.data = wdat;
            wb_q.push_back(w);
        end
        valid_i = vld; aluop_i = op; mem_addr_i = addr; reg2_i = r2;
        wd_i = wd; wreg_i = wr; wdata_i = wdat;
        stalls = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!stallreq_o) break;
            stalls++;
        end
        @(posedge clk); #1;
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
        if (mis) begin
            chk("misalign_pulse", {31'h0, misalign_o}, 32'h1);
            chk("misalign_wreg", {31'h0, wreg_o}, 32'h0);
        end
    endtask

    task automatic idle(input int cyc);
        valid_i = 1'b0;
        repeat (cyc) begin @(posedge clk); #1; end
    endtask

    // Write-back monitor: every wreg_o=1 cycle must match the oldest expected result.
    initial begin
        wb_t w;
        forever begin
            @(posedge clk); #1;
            if (misalign_o) seen_mis++;
            if (wreg_o) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", {27'h0, wd_o}, 32'hFFFF_FFFF);
                end else begin
                    w = wb_q.pop_front();
                    chk("wb_wd", {27'h0, wd_o}, {27'h0, w.wd});
                    chk("wb_wdata", wdata_o, w.data);
                end
            end
        end
    end

    // Bus slave: checks each request, waits the scheduled delay, acks with memory data.
    initial begin
        bus_t e;
        dm_ack_i = 1'b0;
        dm_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            if (dm_req_o) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", dm_addr_o, 32'hFFFF_FFFF);
                    e.delay = 0;
                end else begin
                    e = bus_q.pop_front();
                    chk("bus_addr", dm_addr_o, e.addr);
                    chk("bus_sel", {28'h0, dm_sel_o}, {28'h0, e.sel});
                    chk("bus_we", {31'h0, dm_we_o}, {31'h0, e.we});
                    if (e.we) chk("bus_wdata", dm_wdata_o, e.wdata);
                end
                for (int d = 0; d < e.delay; d++) begin
                    @(posedge clk); #1;
                    if (!abort_ok) chk("bus_req_held", {31'h0, dm_req_o}, 32'h1);
                end
                dm_ack_i = 1'b1;
                dm_rdata_i = dm_we_o ? $urandom : mem[dm_addr_o[9:2]];
                @(posedge clk); #1;
                dm_ack_i = 1'b0;
                chk("bus_req_drop", {31'h0, dm_req_o}, 32'h0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_outputs();
        chk("rst_req", {31'h0, dm_req_o}, 32'h0);
        chk("rst_we", {31'h0, dm_we_o}, 32'h0);
        chk("rst_addr", dm_addr_o, 32'h0);
        chk("rst_sel", {28'h0, dm_sel_o}, 32'h0);
        chk("rst_bwdata", dm_wdata_o, 32'h0);
        chk("rst_mis", {31'h0, misalign_o}, 32'h0);
        chk("rst_wd", {27'h0, wd_o}, 32'h0);
        chk("rst_wreg", {31'h0, wreg_o}, 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
    endtask

    initial begin
        logic [7:0]  ops [10];
        logic [7:0]  op;
        logic [31:0] a;
        int          n;
        ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, 8'b0010_0001, 8'b0010_0101};
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst = 1'b1; valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
        aluop_i = '0; mem_addr_i = '0; reg2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        idle(1);

        do_op(8'b0010_0001, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 0, 1'b1);
        mem[64] = 32'h11F2_3344;
        do_op(EXE_LB_OP, 32'h101, 32'h0, 5'd7, 1'b1, 32'h0, 0, 1'b1);
        idle(2);
        do_op(EXE_LBU_OP, 32'h101, 32'h0, 5'd8, 1'b1, 32'h0, 0, 1'b1);
        idle(2);
        do_op(EXE_SH_OP, 32'h202, 32'hAAAA_BEEF, 5'd0, 1'b0, 32'h202, 3, 1'b1);
        idle(2);
        do_op(EXE_LW_OP, 32'h6, 32'h0, 5'd9, 1'b1, 32'h6, 0, 1'b1);
        idle(2);

        // Reset during the second WAIT cycle; the late ack must be ignored.
        abort_ok = 1'b1;
        bus_q.push_back('{addr: 32'h40, sel: 4'hF, we: 1'b0, wdata: 32'h0, delay: 10});
        valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h40; wd_i = 5'd3; wreg_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; valid_i = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs();
        rst = 1'b0;
        idle(15);
        abort_ok = 1'b0;

        for (int t = 0; t < 300; t++) begin
            op = ops[$urandom_range(0, 9)];
            a = $urandom;
            n = nbytes(op);
            if (n != 0 && $urandom_range(0, 2) != 0) a = a & ~(32'(n) - 32'h1);
            do_op(op, a, $urandom, 5'($urandom), 1'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(6);

        chk("wb_queue_drained", 32'(wb_q.size()), 32'h0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'h0);
        chk("misalign_count", 32'(seen_mis), 32'(exp_mis));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
